// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 arithmetic unit: opcodes, field
// widths, special constants, the unpacked-operand record and small helpers.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    // Exponent arithmetic is done in 11-bit signed so that multiply
    // (up to +256) and divide (down to -254) never wrap.
    localparam logic signed [10:0] BIAS_S = 11'(BIAS);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   mant;     // hidden bit included
        logic              is_zero;  // true zero or flushed subnormal
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

    // Split a binary32 word into fields; subnormals are flushed to zero.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
        fp_unpacked_t u;
        u.sign    = v[31];
        u.is_zero = (v[30:23] == 8'h00);
        u.is_inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        u.is_nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        u.exp     = u.is_zero ? 8'h00 : v[30:23];
        u.mant    = u.is_zero ? 24'h00_0000 : {1'b1, v[22:0]};
        return u;
    endfunction

    // Leading-zero count of a 28-bit vector (28 when the vector is zero).
    function automatic logic [4:0] lzc28(input logic [27:0] v);
        logic [4:0] n;
        n = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (v[i]) begin
                n = 5'(27 - i);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Round-to-nearest-even and pack stage shared by add, multiply and divide.
// Input significand is 27 bits {1.mant[23 bits], guard, round, sticky} with
// the leading one at bit 26; exponent is unbiased. Handles the mantissa
// carry from rounding, overflow to signed Inf and underflow to signed zero.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic               in_sign,
    input  logic signed [10:0] in_exp,
    input  logic [26:0]        in_sig,
    input  logic               in_zero,
    output logic [31:0]        out_val
);

    logic               round_up;
    logic [24:0]        mant_rnd;
    logic [22:0]        frac;
    logic signed [10:0] exp_adj;
    logic signed [10:0] biased;

    // Round, renormalise on carry-out, then range-check the biased exponent.
    always_comb begin
        round_up = in_sig[2] & (in_sig[3] | in_sig[1] | in_sig[0]);
        mant_rnd = {1'b0, in_sig[26:3]} + {24'd0, round_up};
        if (mant_rnd[24]) begin
            frac    = mant_rnd[23:1];
            exp_adj = in_exp + 11'sd1;
        end else begin
            frac    = mant_rnd[22:0];
            exp_adj = in_exp;
        end
        biased = exp_adj + BIAS_S;
        if (in_zero || (biased <= 11'sd0)) begin
            out_val = {in_sign, 31'd0};
        end else if (biased >= 11'sd255) begin
            out_val = {in_sign, 31'd0} | POS_INF;
        end else begin
            out_val = {in_sign, biased[7:0], frac};
        end
    end

endmodule

// File: rtl/fpu_unit.sv
// Two-stage binary32 add/sub/mul/div unit. Edge k registers the operands
// and opcode; edge k+1 registers the rounded result. One op per clock.
// Build option: define FPU_DIV_EN to include the divider; without it the
// divide opcode returns the canonical quiet NaN with the same latency.
module fpu_unit
    import fpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic [1:0]  Operation,
    output logic [31:0] Result
);

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] result_q, result_d;

    fp_unpacked_t ua, ub;
    logic         b_sign_eff;

    logic         spec_hit;
    logic [31:0]  spec_val;

    logic               add_sign, add_zero;
    logic signed [10:0] add_exp;
    logic [26:0]        add_sig;

    logic               mul_sign, mul_zero;
    logic signed [10:0] mul_exp;
    logic [26:0]        mul_sig;

`ifdef FPU_DIV_EN
    logic               div_sign, div_zero;
    logic signed [10:0] div_exp;
    logic [26:0]        div_sig;
`endif

    logic               rp_sign, rp_zero;
    logic signed [10:0] rp_exp;
    logic [26:0]        rp_sig;
    logic [31:0]        rp_val;

    // Stage 1 next-state: sample the operand bus every cycle.
    always_comb begin
        a_d  = Operand1;
        b_d  = Operand2;
        op_d = Operation;
    end

    // Decode both captured operands; subtraction is addition with B negated.
    always_comb begin
        ua         = fp_unpack(a_q);
        ub         = fp_unpack(b_q);
        b_sign_eff = ub.sign ^ (op_q == OP_SUB);
    end

    // NaN/Inf/zero combinations that bypass the arithmetic datapath.
    always_comb begin
        spec_hit = 1'b0;
        spec_val = 32'd0;
        if (ua.is_nan || ub.is_nan) begin
            spec_hit = 1'b1;
            spec_val = QNAN;
        end else begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    if (ua.is_inf && ub.is_inf) begin
                        spec_hit = 1'b1;
                        spec_val = (ua.sign != b_sign_eff) ? QNAN
                                                           : ({ua.sign, 31'd0} | POS_INF);
                    end else if (ua.is_inf) begin
                        spec_hit = 1'b1;
                        spec_val = {ua.sign, 31'd0} | POS_INF;
                    end else if (ub.is_inf) begin
                        spec_hit = 1'b1;
                        spec_val = {b_sign_eff, 31'd0} | POS_INF;
                    end else if (ua.is_zero && ub.is_zero) begin
                        // Only (-0)+(-0) keeps a negative sign.
                        spec_hit = 1'b1;
                        spec_val = {ua.sign & b_sign_eff, 31'd0};
                    end
                end
                OP_MUL: begin
                    if ((ua.is_zero && ub.is_inf) || (ua.is_inf && ub.is_zero)) begin
                        spec_hit = 1'b1;
                        spec_val = QNAN;
                    end else if (ua.is_inf || ub.is_inf) begin
                        spec_hit = 1'b1;
                        spec_val = {ua.sign ^ ub.sign, 31'd0} | POS_INF;
                    end else if (ua.is_zero || ub.is_zero) begin
                        spec_hit = 1'b1;
                        spec_val = {ua.sign ^ ub.sign, 31'd0};
                    end
                end
                default: begin
`ifdef FPU_DIV_EN
                    if ((ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
                        spec_hit = 1'b1;
                        spec_val = QNAN;
                    end else if (ua.is_inf || ub.is_zero) begin
                        spec_hit = 1'b1;
                        spec_val = {ua.sign ^ ub.sign, 31'd0} | POS_INF;
                    end else if (ub.is_inf || ua.is_zero) begin
                        spec_hit = 1'b1;
                        spec_val = {ua.sign ^ ub.sign, 31'd0};
                    end
`else
                    spec_hit = 1'b1;
                    spec_val = QNAN;
`endif
                end
            endcase
        end
    end

    // Add/sub: swap so the larger magnitude leads, align the smaller one with
    // sticky collection, add or subtract, then normalise by leading zeros.
    always_comb begin
        logic        a_bigger, big_sign, sml_sign, eff_sub, sticky;
        logic [7:0]  big_exp, sml_exp, exp_diff;
        logic [23:0] big_mant, sml_mant;
        logic [26:0] big_ext, sml_ext, aligned, lost_mask;
        logic [27:0] sum, norm;
        logic [4:0]  lz;

        a_bigger = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
        big_sign = a_bigger ? ua.sign    : b_sign_eff;
        sml_sign = a_bigger ? b_sign_eff : ua.sign;
        big_exp  = a_bigger ? ua.exp     : ub.exp;
        sml_exp  = a_bigger ? ub.exp     : ua.exp;
        big_mant = a_bigger ? ua.mant    : ub.mant;
        sml_mant = a_bigger ? ub.mant    : ua.mant;
        eff_sub  = big_sign ^ sml_sign;
        exp_diff = big_exp - sml_exp;
        big_ext  = {big_mant, 3'b000};
        sml_ext  = {sml_mant, 3'b000};

        lost_mask = 27'd0;
        if (exp_diff > 8'd26) begin
            aligned = 27'd0;
            sticky  = |sml_mant;
        end else begin
            aligned   = sml_ext >> exp_diff;
            lost_mask = (27'd1 << exp_diff) - 27'd1;
            sticky    = |(sml_ext & lost_mask);
        end
        aligned[0] = aligned[0] | sticky;

        sum = eff_sub ? ({1'b0, big_ext} - {1'b0, aligned})
                      : ({1'b0, big_ext} + {1'b0, aligned});
        lz   = lzc28(sum);
        norm = sum << lz;

        add_exp  = $signed({3'b000, big_exp}) - BIAS_S + 11'sd1 - $signed({6'd0, lz});
        add_sig  = {norm[27:2], |norm[1:0]};
        add_zero = (sum == 28'd0);
        add_sign = add_zero ? 1'b0 : big_sign;   // exact cancellation is +0
    end

    // Multiply: 24x24 product, normalise by at most one position.
    always_comb begin
        logic [47:0]        prod;
        logic signed [10:0] exp_base;

        prod     = 48'(ua.mant) * 48'(ub.mant);
        exp_base = $signed({3'b000, ua.exp}) + $signed({3'b000, ub.exp}) - BIAS_S - BIAS_S;
        if (prod[47]) begin
            mul_sig = {prod[47:22], |prod[21:0]};
            mul_exp = exp_base + 11'sd1;
        end else begin
            mul_sig = {prod[46:21], |prod[20:0]};
            mul_exp = exp_base;
        end
        mul_sign = ua.sign ^ ub.sign;
        mul_zero = ua.is_zero | ub.is_zero;
    end

`ifdef FPU_DIV_EN
    // Divide: unrolled restoring division, 27 quotient bits plus sticky.
    always_comb begin
        logic [24:0]        div_rem;
        logic [26:0]        div_q;
        logic               rem_sticky;
        logic signed [10:0] exp_base;

        div_rem = {1'b0, ua.mant};
        div_q   = 27'd0;
        for (int i = 26; i >= 0; i--) begin
            if (div_rem >= {1'b0, ub.mant}) begin
                div_q[i] = 1'b1;
                div_rem  = div_rem - {1'b0, ub.mant};
            end
            div_rem = div_rem << 1;
        end
        rem_sticky = (div_rem != 25'd0);
        exp_base   = $signed({3'b000, ua.exp}) - $signed({3'b000, ub.exp});
        if (div_q[26]) begin
            div_sig = {div_q[26:1], div_q[0] | rem_sticky};
            div_exp = exp_base;
        end else begin
            div_sig = {div_q[25:0], rem_sticky};
            div_exp = exp_base - 11'sd1;
        end
        div_sign = ua.sign ^ ub.sign;
        div_zero = ua.is_zero;
    end
`endif

    // Route the selected path into the single shared rounder.
    always_comb begin
        case (op_q)
            OP_ADD, OP_SUB: begin
                rp_sign = add_sign;
                rp_exp  = add_exp;
                rp_sig  = add_sig;
                rp_zero = add_zero;
            end
`ifdef FPU_DIV_EN
            OP_DIV: begin
                rp_sign = div_sign;
                rp_exp  = div_exp;
                rp_sig  = div_sig;
                rp_zero = div_zero;
            end
`endif
            default: begin
                rp_sign = mul_sign;
                rp_exp  = mul_exp;
                rp_sig  = mul_sig;
                rp_zero = mul_zero;
            end
        endcase
    end

    fpu_round_pack u_round_pack (
        .in_sign (rp_sign),
        .in_exp  (rp_exp),
        .in_sig  (rp_sig),
        .in_zero (rp_zero),
        .out_val (rp_val)
    );

    // Stage 2 next-state: special-case result wins over the rounded value.
    always_comb begin
        result_d = spec_hit ? spec_val : rp_val;
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 2'b00;
            result_q <= 32'd0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign Result = result_q;

endmodule

// File: tb/tb_fpu_unit.sv
// Directed-vector bench for fpu_unit: arithmetic, rounding, specials,
// back-to-back issue and mid-stream asynchronous reset. Divide expectations
// follow the FPU_DIV_EN build option.
module tb_fpu_unit;

    localparam logic [31:0] QN  = 32'h7FC0_0000;
    localparam logic [31:0] INF = 32'h7F80_0000;
`ifdef FPU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [1:0]  Operation;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fpu_unit dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Operation (Operation),
        .Result    (Result)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Operation = op;
        Operand1  = a;
        Operand2  = b;
    endtask

    // Issue one op and check it two edges later.
    task automatic run_vec(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        issue(op, a, b);
        @(negedge CLK);
        @(negedge CLK);
        check_eq(tag, Result, exp);
    endtask

    initial begin
        RST_N     = 1'b0;
        Operation = 2'b00;
        Operand1  = 32'd0;
        Operand2  = 32'd0;
        repeat (2) @(negedge CLK);
        check_eq("reset", Result, 32'h0000_0000);
        RST_N = 1'b1;

        run_vec("add_1p2",     2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        run_vec("sub_3m3",     2'b01, 32'h4040_0000, 32'h4040_0000, 32'h0000_0000);
        run_vec("add_1pm1",    2'b00, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        run_vec("add_nz_nz",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run_vec("add_tie_even",2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        run_vec("add_rnd_up",  2'b00, 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001);
        run_vec("add_subnorm", 2'b00, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000);
        run_vec("add_inf",     2'b00, INF,           32'h3F80_0000, INF);
        run_vec("mul_2x3",     2'b10, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        run_vec("mul_neg",     2'b10, 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
        run_vec("mul_ovf",     2'b10, 32'h7F7F_FFFF, 32'h4000_0000, INF);
        run_vec("mul_unf",     2'b10, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
        run_vec("mul_round",   2'b10, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
        run_vec("mul_0xinf",   2'b10, 32'h0000_0000, INF,           QN);
        run_vec("div_1d3",     2'b11, 32'h3F80_0000, 32'h4040_0000, DIV_EN ? 32'h3EAA_AAAB : QN);
        run_vec("div_3d2",     2'b11, 32'h4040_0000, 32'h4000_0000, DIV_EN ? 32'h3FC0_0000 : QN);
        run_vec("div_1d0",     2'b11, 32'h3F80_0000, 32'h0000_0000, DIV_EN ? INF : QN);
        run_vec("div_0d0",     2'b11, 32'h0000_0000, 32'h0000_0000, QN);
        run_vec("div_fin_inf", 2'b11, 32'hBF80_0000, INF,           DIV_EN ? 32'h8000_0000 : QN);
        run_vec("inf_m_inf",   2'b01, INF,           INF,           QN);
        run_vec("nan_p_1",     2'b00, 32'h7FA0_0000, 32'h3F80_0000, QN);

        // Back-to-back issue: results emerge in order, one per edge.
        issue(2'b00, 32'h3F80_0000, 32'h4000_0000);
        issue(2'b10, 32'h4000_0000, 32'h4040_0000);
        issue(2'b11, 32'h4040_0000, 32'h4000_0000);
        check_eq("pipe_add", Result, 32'h4040_0000);
        @(negedge CLK);
        check_eq("pipe_mul", Result, 32'h40C0_0000);
        @(negedge CLK);
        check_eq("pipe_div", Result, DIV_EN ? 32'h3FC0_0000 : QN);
        @(negedge CLK);
        check_eq("pipe_hold", Result, DIV_EN ? 32'h3FC0_0000 : QN);

        // Mid-stream asynchronous reset, then refill.
        #2 RST_N = 1'b0;
        #1 check_eq("rst_async", Result, 32'h0000_0000);
        @(negedge CLK);
        check_eq("rst_hold", Result, 32'h0000_0000);
        Operation = 2'b00;
        Operand1  = 32'h3F80_0000;
        Operand2  = 32'h4000_0000;
        RST_N     = 1'b1;
        @(negedge CLK);
        check_eq("refill_1", Result, 32'h0000_0000);
        @(negedge CLK);
        check_eq("refill_2", Result, 32'h4040_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
